// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | aes_pkg : shared GF(2^8) helpers, column geometry and FSM state type for
// |           the MixColumns datapath. Inverse multipliers exist only when
// |           AES_INV_MIXCOL_EN is defined.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package aes_pkg;

  localparam int         COL_W    = 32;
  localparam int         NUM_COLS = 4;
  localparam logic [7:0] GF_RED   = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  typedef logic [NUM_COLS-1:0][COL_W-1:0] block_t;

  function automatic logic [7:0] gf_mult2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mult3(input logic [7:0] a);
    return gf_mult2(a) ^ a;
  endfunction

`ifdef AES_INV_MIXCOL_EN
  // Higher coefficients are built from the x2, x4, x8 chain.
  function automatic logic [7:0] gf_mult9(input logic [7:0] a);
    return gf_mult2(gf_mult2(gf_mult2(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mult0b(input logic [7:0] a);
    return gf_mult2(gf_mult2(gf_mult2(a))) ^ gf_mult2(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mult0d(input logic [7:0] a);
    return gf_mult2(gf_mult2(gf_mult2(a))) ^ gf_mult2(gf_mult2(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mult0e(input logic [7:0] a);
    return gf_mult2(gf_mult2(gf_mult2(a))) ^ gf_mult2(gf_mult2(a)) ^ gf_mult2(a);
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/mixcol_word.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mixcol_word : combinational (Inv)MixColumns on one 32-bit column, row 0 in
// |               the top byte. mode selects inverse only with AES_INV_MIXCOL_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mixcol_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col,
  input  logic             mode,
  output logic [COL_W-1:0] res
);

  logic [7:0]       w_a0, w_a1, w_a2, w_a3;
  logic [COL_W-1:0] w_fwd;

  assign {w_a0, w_a1, w_a2, w_a3} = col;

  assign w_fwd = {gf_mult2(w_a0) ^ gf_mult3(w_a1) ^ w_a2 ^ w_a3,
                  w_a0 ^ gf_mult2(w_a1) ^ gf_mult3(w_a2) ^ w_a3,
                  w_a0 ^ w_a1 ^ gf_mult2(w_a2) ^ gf_mult3(w_a3),
                  gf_mult3(w_a0) ^ w_a1 ^ w_a2 ^ gf_mult2(w_a3)};

`ifdef AES_INV_MIXCOL_EN
  logic [COL_W-1:0] w_inv;

  assign w_inv = {gf_mult0e(w_a0) ^ gf_mult0b(w_a1) ^ gf_mult0d(w_a2) ^ gf_mult9(w_a3),
                  gf_mult9(w_a0) ^ gf_mult0e(w_a1) ^ gf_mult0b(w_a2) ^ gf_mult0d(w_a3),
                  gf_mult0d(w_a0) ^ gf_mult9(w_a1) ^ gf_mult0e(w_a2) ^ gf_mult0b(w_a3),
                  gf_mult0b(w_a0) ^ gf_mult0d(w_a1) ^ gf_mult9(w_a2) ^ gf_mult0e(w_a3)};

  assign res = mode ? w_inv : w_fwd;
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign res           = w_fwd;
`endif

endmodule
`default_nettype wire

// File: rtl/mixcolumns_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mixcolumns_pipe : iterative MixColumns over a 128-bit block, COLS_PER_CYCLE
// |                   columns per cycle; InvMixColumns via AES_INV_MIXCOL_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mixcolumns_pipe
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic         dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % NUM_COLS);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

  fsm_state_t       r_state, w_next_state;
  logic [1:0]       r_col;
  block_t           r_buf, w_next_buf;
  logic             w_mode;
  logic             w_in_fire, w_out_fire, w_last;
  logic [1:0]       w_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] w_res [COLS_PER_CYCLE];

  assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid  = (r_state == DONE);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_last     = (r_col == LAST_COL);

`ifdef AES_INV_MIXCOL_EN
  logic r_dec;

  assign w_mode = r_dec;
`else
  logic w_unused_dec;

  assign w_unused_dec = dec;
  assign w_mode       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_in_fire) w_next_state = BUSY;
      BUSY:    if (w_last) w_next_state = DONE;
      DONE:    if (w_out_fire) w_next_state = w_in_fire ? BUSY : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign w_idx[j] = r_col + 2'(j);

    mixcol_word u_word (
      .col  (r_buf[w_idx[j]]),
      .mode (w_mode),
      .res  (w_res[j])
    );
  end

  // Results replace their source columns in place, so the buffer ends up
  // holding the finished block on the last BUSY cycle.
  always_comb begin
    w_next_buf = r_buf;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_next_buf[w_idx[j]] = w_res[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= 2'd0;
      r_buf <= '0;
      out   <= 128'h0;
`ifdef AES_INV_MIXCOL_EN
      r_dec <= 1'b0;
`endif
    end else if (w_in_fire) begin
      r_col <= 2'd0;
      r_buf <= state;
`ifdef AES_INV_MIXCOL_EN
      r_dec <= dec;
`endif
    end else if (r_state == BUSY) begin
      r_col <= r_col + COL_STEP;
      r_buf <= w_next_buf;
      if (w_last) out <= w_next_buf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mixcolumns_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_mixcolumns_pipe : runs all three column widths (1, 2, 4) against a
// |                      GF(2^8) matrix reference; honours AES_INV_MIXCOL_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_mixcolumns_pipe;

`ifdef AES_INV_MIXCOL_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, dec;
  logic [127:0] state_a [3];
  logic [127:0] out_a   [3];

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           act   = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  bit           seen  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mixcolumns_pipe #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .state     (state_a[k]),
      .dec       (dec[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out       (out_a[k])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s C=%0d got=%h exp=%h", tag, 1 << act, got, expv);
    end
  endtask

  // Generic shift-and-add field multiply, modulus x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Circulant matrix product per column: r_row = sum_i cf[(i-row) mod 4] * a_i.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic d);
    logic [7:0]   cf [4];
    logic [127:0] r = '0;
    logic [7:0]   acc;
    if (d && INV_EN) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else             cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) acc ^= gmul(cf[(i - row + 4) % 4], s[32*c + 31 - 8*i -: 8]);
        r[32*c + 31 - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Scoreboard on the falling edge: transfers seen here happen at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      seen = 1'b0;
    end else begin
      if (out_valid[act] && !seen) begin
        seen = 1'b1;
        if (acc_q.size() == 0) check_eq("spurious_valid", 128'(acc_q.size()), 128'(1));
        else                   check_eq("latency", 128'(cyc - acc_q[0]), 128'(4 >> act));
      end
      if (out_valid[act] && out_ready[act] && exp_q.size() > 0) begin
        check_eq("result", out_a[act], exp_q.pop_front());
        void'(acc_q.pop_front());
        seen = 1'b0;
      end
      if (in_valid[act] && in_ready[act]) begin
        exp_q.push_back(ref_mix(state_a[act], dec[act]));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [127:0] blk, input logic d);
    int t = 0;
    state_a[k]  = blk;
    dec[k]      = d;
    in_valid[k] = 1'b1;
    #1;
    while (!in_ready[k] && t < 50) begin
      tick();
      t++;
    end
    check_eq("send_ready", 128'(in_ready[k]), 128'(1));
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int t = 0;
    while (!out_valid[k] && t < 20) begin
      tick();
      t++;
    end
    check_eq("valid_seen", 128'(out_valid[k]), 128'(1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] fips_in, fips_out, held, blk, inv_exp;
    int           n_acc;
    bit           fire;
    fips_in   = {32'hd4d4d4d5, 32'h01010101, 32'hf20a225c, 32'hdb135345};
    fips_out  = {32'hd5d5d7d6, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc};
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    dec       = '0;
    for (int k = 0; k < 3; k++) state_a[k] = '0;

    for (int k = 0; k < 3; k++) begin
      act = k;
      rst = 1'b1;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      repeat (3) tick();
      check_eq("rst_out", out_a[k], 128'h0);
      check_eq("rst_valid", 128'(out_valid[k]), 128'(0));
      rst = 1'b0;
      #1;
      check_eq("ready_after_rst", 128'(in_ready[k]), 128'(1));
      out_ready[k] = 1'b1;

      send(k, fips_in, 1'b0);
      wait_valid(k);
      check_eq("fips_fwd", out_a[k], fips_out);

      if (INV_EN) inv_exp = fips_in;
      else        inv_exp = ref_mix(fips_out, 1'b0);
      send(k, fips_out, 1'b1);
      wait_valid(k);
      check_eq("fips_inv", out_a[k], inv_exp);

      // Backpressure, then simultaneous output and input transfer.
      tick();
      out_ready[k] = 1'b0;
      send(k, rnd128(), 1'b0);
      wait_valid(k);
      held = out_a[k];
      repeat (10) begin
        tick();
        check_eq("bp_out", out_a[k], held);
        check_eq("bp_ready", 128'(in_ready[k]), 128'(0));
        check_eq("bp_valid", 128'(out_valid[k]), 128'(1));
      end
      state_a[k]   = rnd128();
      dec[k]       = 1'b0;
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b1;
      #1;
      check_eq("bp_ready_rel", 128'(in_ready[k]), 128'(1));
      tick();
      in_valid[k] = 1'b0;
      check_eq("bp_busy", 128'(out_valid[k]), 128'(0));
      wait_valid(k);

      // Input isolation.
      tick();
      blk = rnd128();
      send(k, blk, 1'b0);
      state_a[k] = '1;
      dec[k]     = 1'b1;
      wait_valid(k);
      check_eq("isolation", out_a[k], ref_mix(blk, 1'b0));

      // Reset in the middle of a block.
      tick();
      send(k, rnd128(), 1'b0);
      if (k < 2) tick();
      rst = 1'b1;
      tick();
      check_eq("midrst_valid", 128'(out_valid[k]), 128'(0));
      check_eq("midrst_out", out_a[k], 128'h0);
      rst = 1'b0;
      #1;
      check_eq("midrst_ready", 128'(in_ready[k]), 128'(1));

      // Random streaming with sporadic consumer stalls.
      n_acc       = 0;
      state_a[k]  = rnd128();
      dec[k]      = 1'($urandom_range(0, 1));
      in_valid[k] = 1'b1;
      for (int t = 0; t < 3000 && n_acc < 100; t++) begin
        out_ready[k] = ($urandom_range(0, 3) != 0);
        #1;
        fire = in_valid[k] && in_ready[k];
        tick();
        if (fire) begin
          n_acc++;
          state_a[k] = rnd128();
          dec[k]     = 1'($urandom_range(0, 1));
        end
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      check_eq("stream_count", 128'(n_acc), 128'(100));
      for (int t = 0; t < 50 && exp_q.size() > 0; t++) tick();
      check_eq("drain", 128'(exp_q.size()), 128'(0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
